// File: rtl/scr1_ialu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scr1_ialu_arb_pkg
// Description : Shared definitions for the main-adder arbiter: flag bit
//               positions inside the {Z,S,O,C} vector, adder command
//               encodings and the response-slot state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package scr1_ialu_arb_pkg;

   // Bit positions of the adder flags inside the 4-bit flag vector
   localparam int FLAG_Z = 3;
   localparam int FLAG_S = 2;
   localparam int FLAG_O = 1;
   localparam int FLAG_C = 0;

   // Adder command encodings
   localparam logic CMD_ADD = 1'b0;
   localparam logic CMD_SUB = 1'b1;

   // Response slot occupancy
   typedef enum logic [0:0] {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage : scr1_ialu_arb_pkg
`default_nettype wire

// File: rtl/scr1_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : scr1_rr_pick
// Description : Combinational round-robin first-set finder. Scans req upward
//               starting at ptr, wrapping from NREQ-1 to 0, and reports the
//               first set requester as a one-hot grant plus its index.
// Ports       : req  - request vector
//               ptr  - scan start position (must be < NREQ)
//               gnt  - one-hot grant (zero when no request)
//               idx  - index of the granted requester (0 when none)
//               any  - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module scr1_rr_pick
   import scr1_ialu_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   int w_cand;

   // Walk offsets from farthest to nearest so the closest set requester to
   // ptr is the last one written and therefore wins.
   always_comb begin
      gnt    = '0;
      idx    = '0;
      any    = 1'b0;
      w_cand = 0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         w_cand = int'(ptr) + off;
         if (w_cand >= NREQ) begin
            w_cand = w_cand - NREQ;
         end
         if (req[w_cand[IDW-1:0]]) begin
            gnt                  = '0;
            gnt[w_cand[IDW-1:0]] = 1'b1;
            idx                  = w_cand[IDW-1:0];
            any                  = 1'b1;
         end
      end
   end

endmodule : scr1_rr_pick
`default_nettype wire

// File: rtl/scr1_ialu_add_arb.sv
`default_nettype none
// ============================================================================
// Module      : scr1_ialu_add_arb
// Description : Round-robin arbiter sharing one combinational main adder
//               between NREQ requesters. One operation accepted per cycle;
//               result and flags are captured in a single registered
//               response slot tagged with the winning requester ID.
// Ports       : clk, rst                      - clock, async active-high reset
//               req_vld_i / req_rdy_o         - per-requester handshake
//               req_op1_i / req_op2_i         - packed operands, [i*XLEN +: XLEN]
//               req_cmd_i                     - per-requester cmd (0 add, 1 sub)
//               arb2add_op1_o/op2_o/cmd_o     - to the shared adder
//               add2arb_res_i / add2arb_flags_i - from the shared adder
//               rsp_vld_o / rsp_rdy_i         - response slot handshake
//               rsp_id_o/res_o/flags_o        - registered response
// Revision    : 1.0 - initial release
// ============================================================================
module scr1_ialu_add_arb
   import scr1_ialu_arb_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_vld_i,
   output logic [NREQ-1:0]      req_rdy_o,
   input  logic [NREQ*XLEN-1:0] req_op1_i,
   input  logic [NREQ*XLEN-1:0] req_op2_i,
   input  logic [NREQ-1:0]      req_cmd_i,
   output logic [XLEN-1:0]      arb2add_op1_o,
   output logic [XLEN-1:0]      arb2add_op2_o,
   output logic                 arb2add_cmd_o,
   input  logic [XLEN-1:0]      add2arb_res_i,
   input  logic [3:0]           add2arb_flags_i,
   output logic                 rsp_vld_o,
   input  logic                 rsp_rdy_i,
   output logic [IDW-1:0]       rsp_id_o,
   output logic [XLEN-1:0]      rsp_res_o,
   output logic [3:0]           rsp_flags_o
);

   slot_state_e     r_state;
   slot_state_e     w_state_nxt;
   logic [IDW-1:0]  r_rr_ptr;
   logic [IDW-1:0]  w_ptr_nxt;
   logic [NREQ-1:0] w_pick_gnt;
   logic [IDW-1:0]  w_pick_idx;
   logic            w_pick_any;
   logic            w_can_accept;
   logic            w_grant;
   logic [IDW-1:0]  w_sel_idx;

   scr1_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .req (req_vld_i),
      .ptr (r_rr_ptr),
      .gnt (w_pick_gnt),
      .idx (w_pick_idx),
      .any (w_pick_any)
   );

   // Slot frees up when empty or being drained this cycle. The rst term keeps
   // grants silent while reset is held, before the flops have been cleared.
   assign w_can_accept = (r_state == SLOT_EMPTY) || rsp_rdy_i;
   assign w_grant      = w_can_accept && w_pick_any && !rst;
   assign req_rdy_o    = w_grant ? w_pick_gnt : '0;

   // Without a grant, the pointer's requester still drives the adder so its
   // inputs never float.
   assign w_sel_idx     = w_grant ? w_pick_idx : r_rr_ptr;
   assign arb2add_op1_o = req_op1_i[int'(w_sel_idx)*XLEN +: XLEN];
   assign arb2add_op2_o = req_op2_i[int'(w_sel_idx)*XLEN +: XLEN];
   assign arb2add_cmd_o = req_cmd_i[w_sel_idx];

   assign w_ptr_nxt = (w_pick_idx == IDW'(NREQ - 1)) ? '0 : w_pick_idx + IDW'(1);

   // Slot FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SLOT_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Slot FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SLOT_EMPTY: if (w_grant) w_state_nxt = SLOT_FULL;
         SLOT_FULL : if (!w_grant && rsp_rdy_i) w_state_nxt = SLOT_EMPTY;
         default   : w_state_nxt = SLOT_EMPTY;
      endcase
   end

   // Slot FSM: outputs
   always_comb begin
      rsp_vld_o = (r_state == SLOT_FULL);
   end

   // Response payload and round-robin pointer; they only move on a grant, so
   // a drained slot keeps its last contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_res_o   <= '0;
         rsp_flags_o <= '0;
         rsp_id_o    <= '0;
         r_rr_ptr    <= '0;
      end else if (w_grant) begin
         rsp_res_o   <= add2arb_res_i;
         rsp_flags_o <= add2arb_flags_i;
         rsp_id_o    <= w_pick_idx;
         r_rr_ptr    <= w_ptr_nxt;
      end
   end

endmodule : scr1_ialu_add_arb
`default_nettype wire

// File: tb/tb_scr1_ialu_add_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_scr1_ialu_add_arb
// Description : Directed self-checking bench for scr1_ialu_add_arb (NREQ=4)
//               with a behavioural shared adder and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scr1_ialu_add_arb;
   import scr1_ialu_arb_pkg::*;

   localparam int XLEN = 32;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   typedef struct {
      logic [IDW-1:0]  id;
      logic [XLEN-1:0] res;
      logic [3:0]      flags;
   } rsp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_vld;
   logic [NREQ-1:0]      req_rdy;
   logic [NREQ*XLEN-1:0] req_op1;
   logic [NREQ*XLEN-1:0] req_op2;
   logic [NREQ-1:0]      req_cmd;
   logic [XLEN-1:0]      a_op1, a_op2, a_res;
   logic                 a_cmd;
   logic [3:0]           a_flags;
   logic                 rsp_vld, rsp_rdy;
   logic [IDW-1:0]       rsp_id;
   logic [XLEN-1:0]      rsp_res;
   logic [3:0]           rsp_flags;

   int   nvec = 0;
   int   nerr = 0;
   rsp_t sb[$];
   rsp_t last;
   bit   pending;

   always #5 clk = ~clk;

   scr1_ialu_add_arb #(.XLEN(XLEN), .NREQ(NREQ)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_vld_i       (req_vld),
      .req_rdy_o       (req_rdy),
      .req_op1_i       (req_op1),
      .req_op2_i       (req_op2),
      .req_cmd_i       (req_cmd),
      .arb2add_op1_o   (a_op1),
      .arb2add_op2_o   (a_op2),
      .arb2add_cmd_o   (a_cmd),
      .add2arb_res_i   (a_res),
      .add2arb_flags_i (a_flags),
      .rsp_vld_o       (rsp_vld),
      .rsp_rdy_i       (rsp_rdy),
      .rsp_id_o        (rsp_id),
      .rsp_res_o       (rsp_res),
      .rsp_flags_o     (rsp_flags)
   );

   // Reference main adder: returns {Z,S,O,C, result}; C is carry for add,
   // borrow for sub.
   function automatic logic [XLEN+3:0] adder(input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b,
                                             input logic cmd);
      logic [XLEN:0] s;
      logic          ov;
      s  = (cmd == CMD_SUB) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      ov = (cmd == CMD_SUB) ? ((a[XLEN-1] != b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]))
                            : ((a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]));
      return {(s[XLEN-1:0] == '0), s[XLEN-1], ov, s[XLEN], s[XLEN-1:0]};
   endfunction

   always_comb begin
      {a_flags, a_res} = adder(a_op1, a_op2, a_cmd);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic c);
      req_vld[i]              = v;
      req_op1[i*XLEN +: XLEN] = a;
      req_op2[i*XLEN +: XLEN] = b;
      req_cmd[i]              = c;
   endtask

   // One clock: at the falling edge check the response slot (new entry from
   // the scoreboard, or held contents) and the grant vector, record the
   // expected response of any grant, then step past the rising edge.
   task automatic cycle(input logic [NREQ-1:0] exp_rdy, input logic exp_vld);
      rsp_t e;
      int   w;
      @(negedge clk);
      check("rsp_vld", 64'(rsp_vld), 64'(exp_vld));
      if (pending) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 64'(1), 64'(0));
         end else begin
            e    = sb.pop_front();
            last = e;
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_res", 64'(rsp_res), 64'(e.res));
            check("rsp_flags", 64'(rsp_flags), 64'(e.flags));
         end
      end else if (exp_vld) begin
         check("hold_id", 64'(rsp_id), 64'(last.id));
         check("hold_res", 64'(rsp_res), 64'(last.res));
         check("hold_flags", 64'(rsp_flags), 64'(last.flags));
      end
      check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
      pending = 1'b0;
      if (exp_rdy != '0) begin
         w = 0;
         for (int k = 0; k < NREQ; k++) if (exp_rdy[k]) w = k;
         e.id = IDW'(w);
         {e.flags, e.res} = adder(req_op1[w*XLEN +: XLEN], req_op2[w*XLEN +: XLEN], req_cmd[w]);
         sb.push_back(e);
         pending = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rsp_rdy = 1'b1; req_vld = '0; req_op1 = '0; req_op2 = '0; req_cmd = '0;
      pending = 1'b0;
      last = '{id: '0, res: '0, flags: '0};
      set_req(0, 1'b1, 32'd1, 32'd1, CMD_ADD);
      repeat (2) @(posedge clk);
      #1;
      check("reset_rdy", 64'(req_rdy), 64'(0));
      check("reset_vld", 64'(rsp_vld), 64'(0));
      check("reset_id", 64'(rsp_id), 64'(0));
      check("reset_res", 64'(rsp_res), 64'(0));
      check("reset_flags", 64'(rsp_flags), 64'(0));
      rst = 1'b0;

      // Single add, one-cycle latency
      set_req(0, 1'b1, 32'd5, 32'd7, CMD_ADD);
      cycle(4'b0001, 1'b0);
      check("add_res", 64'(rsp_res), 64'd12);
      check("add_flags", 64'(rsp_flags), 64'(4'b0000));
      check("add_id", 64'(rsp_id), 64'd0);

      // Two competitors alternate while the consumer is always ready
      set_req(0, 1'b1, 32'd10, 32'd20, CMD_ADD);
      set_req(1, 1'b1, 32'd50, 32'd8, CMD_SUB);
      cycle(4'b0010, 1'b1);
      cycle(4'b0001, 1'b1);
      cycle(4'b0010, 1'b1);
      cycle(4'b0001, 1'b1);

      // Zero result from sub, then signed overflow on add
      set_req(0, 1'b0, 32'd0, 32'd0, CMD_ADD);
      set_req(1, 1'b1, 32'd3, 32'd3, CMD_SUB);
      cycle(4'b0010, 1'b1);
      check("sub0_res", 64'(rsp_res), 64'd0);
      check("sub0_flags", 64'(rsp_flags), 64'(4'b1000));
      set_req(1, 1'b0, 32'd0, 32'd0, CMD_ADD);
      set_req(0, 1'b1, 32'h7FFF_FFFF, 32'd1, CMD_ADD);
      cycle(4'b0001, 1'b1);
      check("ovf_res", 64'(rsp_res), 64'h8000_0000);
      check("ovf_flags", 64'(rsp_flags), 64'(4'b0110));

      // Backpressure: no grants, response held; release drains and grants
      rsp_rdy = 1'b0;
      set_req(0, 1'b1, 32'd1, 32'd2, CMD_ADD);
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b1);
      check("bp_res", 64'(rsp_res), 64'h8000_0000);
      rsp_rdy = 1'b1;
      cycle(4'b0001, 1'b1);
      set_req(0, 1'b0, 32'd0, 32'd0, CMD_ADD);
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b0);

      // Move pointer to 2, then req3/req1 contend: 3 first, then wrap to 1
      set_req(1, 1'b1, 32'd100, 32'd1, CMD_SUB);
      cycle(4'b0010, 1'b0);
      set_req(3, 1'b1, 32'hFFFF_FFFF, 32'd1, CMD_ADD);
      cycle(4'b1000, 1'b1);
      check("carry_flags", 64'(rsp_flags), 64'(4'b1001));
      set_req(3, 1'b0, 32'd0, 32'd0, CMD_ADD);
      cycle(4'b0010, 1'b1);
      set_req(1, 1'b0, 32'd0, 32'd0, CMD_ADD);
      cycle(4'b0000, 1'b1);

      // Fill the slot (pointer left at 1), then reset mid-operation
      set_req(0, 1'b1, 32'd9, 32'd4, CMD_SUB);
      cycle(4'b0001, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_vld", 64'(rsp_vld), 64'(0));
      check("arst_res", 64'(rsp_res), 64'(0));
      check("arst_rdy", 64'(req_rdy), 64'(0));
      sb.delete();
      pending = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_req(3, 1'b1, 32'd2, 32'd2, CMD_ADD);
      cycle(4'b0001, 1'b0);
      check("post_rst_id", 64'(rsp_id), 64'd0);
      set_req(0, 1'b0, 32'd0, 32'd0, CMD_ADD);
      set_req(3, 1'b0, 32'd0, 32'd0, CMD_ADD);
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule : tb_scr1_ialu_add_arb
`default_nettype wire
